score_digit_controller: RTL and testbench
=========================================

Name: score_digit_controller

Overview:
- Sequences the shared 10-glyph number sprite ROM so it can render a multi-digit decimal score.
- Converts a binary score to BCD sequentially (double-dabble) and double-buffers the result so digits only change at frame start.
- Per pixel, selects the glyph index and origin for the digit slot under the beam; drives the number sprite's number/x/y/hcount/vcount inputs.
- Sits between game-state logic and the number sprite in the video pipeline.

Parameters:
- NUM_DIGITS, 4, number of displayed decimal digits (1..6).
- SCORE_W, 14, binary score width.
- GLYPH_W, 24, glyph width in pixels; also the horizontal slot pitch.
- GLYPH_H, 24, glyph height in pixels.

Ports:
- pixel_clk_in  in  1  pixel clock.
- rst_n_in  in  1  asynchronous active-low reset.
- score_in  in  SCORE_W  binary score.
- score_valid_in  in  1  one-cycle pulse; samples score_in.
- frame_start_in  in  1  one-cycle pulse at start of frame (vsync).
- x_in  in  11  left edge of the most-significant digit.
- y_in  in  10  top edge of all digits.
- hcount_in  in  11  beam x.
- vcount_in  in  10  beam y.
- number_out  out  4  glyph index for the current slot (0..9).
- glyph_x_out  out  11  slot origin x = x_in + k*GLYPH_W.
- glyph_y_out  out  10  equals y_in, registered.
- hcount_out  out  11  hcount_in delayed 1 cycle.
- vcount_out  out  10  vcount_in delayed 1 cycle.
- blank_out  out  1  suppress draw for this slot.
- busy_out  out  1  conversion in progress.

Behaviour:
- Clock and reset: single clock pixel_clk_in; reset is asynchronous and active-low on rst_n_in.
- Reset values: all outputs 0; FSM in IDLE; display and shadow BCD registers all zero; pending flag clear.
- Score capture: score_valid_in loads pending_score and sets pending in any state. Last write wins; earlier uncommitted values are dropped.
- FSM states: IDLE, CONVERT, READY.
  - IDLE: if pending, clear pending, load the converter, go to CONVERT.
  - CONVERT: runs exactly SCORE_W cycles. Each cycle, every BCD nibble >= 5 gets +3, then the whole register shifts left by 1. At the end, write the shadow register and go to READY.
  - READY: on frame_start_in, copy shadow to display and go to IDLE.
- busy_out is 1 in CONVERT and READY.
- Saturation: if score >= 10^NUM_DIGITS, the shadow register is forced to all 9s. Internal BCD width covers ceil(SCORE_W*0.302)+1 digits before saturation.
- Simultaneous events:
  - score_valid_in during CONVERT or READY sets pending; the new conversion starts after the next commit.
  - frame_start_in outside READY is ignored.
  - frame_start_in on the cycle CONVERT finishes does not commit; the next frame commits.
- Reset mid-conversion aborts the conversion; display returns to 0.
- Slot decode, 1-cycle registered latency:
  - k = slot with x_in + k*GLYPH_W <= hcount_in < x_in + (k+1)*GLYPH_W, for k in 0..NUM_DIGITS-1.
  - Use parallel comparators against constant multiples; no divider.
  - number_out = display digit (NUM_DIGITS-1-k), i.e. MSD on the left.
  - Outside all slots: number_out = 0 and blank_out = 1.
  - The vertical range is checked downstream by the sprite.
  - hcount_out/vcount_out/glyph_*_out are aligned with number_out on the same cycle.
- Arithmetic: slot bounds are computed at 12 bits, so x_in + NUM_DIGITS*GLYPH_W beyond 2047 does not wrap; hcount_in never reaches the bound.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: blank_out = 1 for slots whose digit and all more-significant digits are zero. The least-significant digit is never blanked, so 0 shows as a single "0".
- Undefined: blank_out is 1 only outside all slots; all digits are shown, e.g. "0042".

Decomposition:
- Package score_digit_pkg holds:
  - typedef bcd_digit_t (logic [3:0]).
  - enum ctrl_state_t {IDLE, CONVERT, READY}.
  - Constants DIGIT_MAX=4'd9 and BCD_ADD3_THRESH=4'd5.
- Sub-module bin_to_bcd_seq holds the double-dabble shift/add-3 datapath, with ports start/done/bin_in/bcd_out. The controller keeps the FSM, buffering and slot decode.

Test Plan:
- Reset, then score_valid_in with score_in=1234, then frame_start_in → busy_out high for 14+ cycles. After the commit, sweeping hcount from x_in=100 gives number_out 1,2,3,4 at hcount 100,124,148,172, one cycle later.
- score=42 with LEADING_ZERO_BLANK_EN:
  - Macro defined → blank_out=1 for slots 0-1 and 0 for slots 2-3.
  - Macro undefined → blank_out=0 for all slots; digits read 0,0,4,2.
- score=12000 (exceeds 9999) → after commit every slot shows 9.
- Score 500 converted (READY, no frame_start yet), then score 7 pulsed → display still shows the old value until frame_start. It then shows 0500. The next frame_start shows 0007; the value 500 is not dropped.
- frame_start_in on the exact cycle CONVERT completes → no commit. Commit happens on the following frame_start_in.
- rst_n_in asserted mid-CONVERT (async, between clock edges) → outputs 0 immediately. After release, busy_out=0 and the display shows 0000.

Source files
------------

// File: rtl/score_digit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_digit_pkg
// Description : Shared types and constants for the score digit controller and
//               its sequential binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
package score_digit_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        READY   = 2'd2
    } ctrl_state_t;

    localparam bcd_digit_t DIGIT_MAX       = 4'd9;
    localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;

    // Decimal digits needed for a bin_w-bit value: ceil(bin_w*log10(2)) plus
    // one spare digit, using 0.302 as the log10(2) approximation.
    function automatic int bcd_digits_for(input int bin_w);
        return ((bin_w * 302) + 999) / 1000 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential double-dabble converter. A start pulse loads
//               bin_in; BIN_W shift cycles follow. done is high during the
//               final shift cycle and bcd_out then carries the finished
//               result (the value being written by that cycle).
// Ports       : pixel_clk_in, rst_n_in (async, active-low), start, bin_in,
//               done, bcd_out
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
    import score_digit_pkg::*;
#(
    parameter int BIN_W      = 14,
    parameter int BCD_DIGITS = 6
) (
    input  logic                    pixel_clk_in,
    input  logic                    rst_n_in,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    done,
    output logic [BCD_DIGITS*4-1:0] bcd_out
);

    localparam int               CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(BIN_W - 1);

    logic [BIN_W-1:0]        r_bin;
    logic [BCD_DIGITS*4-1:0] r_bcd;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_active;

    logic [BCD_DIGITS*4-1:0] w_adj;
    logic [BCD_DIGITS*4-1:0] w_next_bcd;
    logic [BIN_W-1:0]        w_next_bin;

    // Add-3 correction on every nibble that would overflow past 9 once doubled.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= BCD_ADD3_THRESH) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign {w_next_bcd, w_next_bin} = {w_adj, r_bin} << 1;

    assign done    = r_active && (r_cnt == c_last);
    assign bcd_out = w_next_bcd;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_bin    <= bin_in;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_bin <= w_next_bin;
            r_bcd <= w_next_bcd;
            r_cnt <= r_cnt + CNT_W'(1);
            if (done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/score_digit_controller.sv
`default_nettype none
// ============================================================================
// Module      : score_digit_controller
// Description : Converts a binary score to BCD, double-buffers it so digits
//               only change at frame start, and per pixel drives the number
//               sprite with the glyph index and origin of the slot under the
//               beam (one cycle registered latency).
// Ports       : pixel_clk_in, rst_n_in (async, active-low),
//               score_in/score_valid_in (score update), frame_start_in,
//               x_in/y_in (digit origin), hcount_in/vcount_in (beam),
//               number_out, glyph_x_out, glyph_y_out, hcount_out,
//               vcount_out, blank_out, busy_out
// Options     : LEADING_ZERO_BLANK_EN - blank leading zero digits (the least
//               significant digit is always shown)
// Revision    : 1.0 - initial release
// ============================================================================
module score_digit_controller
    import score_digit_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCORE_W    = 14,
    parameter int GLYPH_W    = 24,
    parameter int GLYPH_H    = 24
) (
    input  logic               pixel_clk_in,
    input  logic               rst_n_in,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_valid_in,
    input  logic               frame_start_in,
    input  logic [10:0]        x_in,
    input  logic [9:0]         y_in,
    input  logic [10:0]        hcount_in,
    input  logic [9:0]         vcount_in,
    output logic [3:0]         number_out,
    output logic [10:0]        glyph_x_out,
    output logic [9:0]         glyph_y_out,
    output logic [10:0]        hcount_out,
    output logic [9:0]         vcount_out,
    output logic               blank_out,
    output logic               busy_out
);

    localparam int c_bcd_digits = bcd_digits_for(SCORE_W);
    localparam int c_ext_digits = (c_bcd_digits > NUM_DIGITS) ? c_bcd_digits : NUM_DIGITS;

    // Glyph height matters only to the sprite's vertical range check.
    localparam logic [31:0] c_glyph_h = 32'(GLYPH_H);
    logic w_unused;
    assign w_unused = ^c_glyph_h;

    ctrl_state_t r_state, w_next_state;
    logic        w_start, w_shadow_we, w_commit;

    logic                          r_pending;
    logic [SCORE_W-1:0]            r_pending_score;
    bcd_digit_t [NUM_DIGITS-1:0]   r_shadow;
    bcd_digit_t [NUM_DIGITS-1:0]   r_display;
    bcd_digit_t [NUM_DIGITS-1:0]   w_shadow_next;

    logic                          w_conv_done;
    logic [c_bcd_digits*4-1:0]     w_conv_bcd;
    logic [c_ext_digits*4-1:0]     w_bcd_ext;
    logic                          w_sat;

    bin_to_bcd_seq #(
        .BIN_W      (SCORE_W),
        .BCD_DIGITS (c_bcd_digits)
    ) u_bin_to_bcd (
        .pixel_clk_in (pixel_clk_in),
        .rst_n_in     (rst_n_in),
        .start        (w_start),
        .bin_in       (r_pending_score),
        .done         (w_conv_done),
        .bcd_out      (w_conv_bcd)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= IDLE;
        else           r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_shadow_we  = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending) begin
                    w_start      = 1'b1;
                    w_next_state = CONVERT;
                end
            end
            CONVERT: begin
                if (w_conv_done) begin
                    w_shadow_we  = 1'b1;
                    w_next_state = READY;
                end
            end
            READY: begin
                if (frame_start_in) begin
                    w_commit     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign busy_out = (r_state != IDLE);

    // A fresh score takes priority over the clear so a write landing on the
    // start cycle is kept for the following conversion.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pending       <= 1'b0;
            r_pending_score <= '0;
        end else if (score_valid_in) begin
            r_pending       <= 1'b1;
            r_pending_score <= score_in;
        end else if (w_start) begin
            r_pending <= 1'b0;
        end
    end

    // ---------------- saturation and double buffer ----------------
    assign w_bcd_ext = (c_ext_digits*4)'(w_conv_bcd);

    always_comb begin
        w_sat = 1'b0;
        for (int i = NUM_DIGITS; i < c_ext_digits; i++) begin
            if (w_bcd_ext[4*i +: 4] != 4'd0) w_sat = 1'b1;
        end
        w_shadow_next = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            w_shadow_next[d] = w_sat ? DIGIT_MAX : w_bcd_ext[4*d +: 4];
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_shadow  <= '0;
            r_display <= '0;
        end else begin
            if (w_shadow_we) r_shadow  <= w_shadow_next;
            if (w_commit)    r_display <= r_shadow;
        end
    end

    // ---------------- slot decode ----------------
    // 12-bit bounds so slots running past the screen edge never wrap.
    logic [NUM_DIGITS:0][11:0] w_bound;
    logic [NUM_DIGITS:0]       w_ge;

    generate
        for (genvar k = 0; k <= NUM_DIGITS; k++) begin : g_bound
            assign w_bound[k] = {1'b0, x_in} + 12'(k * GLYPH_W);
            assign w_ge[k]    = ({1'b0, hcount_in} >= w_bound[k]);
        end
    endgenerate

    logic [NUM_DIGITS-1:0] w_lz_blank;

`ifdef LEADING_ZERO_BLANK_EN
    logic w_lz_run;
    always_comb begin
        w_lz_run   = 1'b1;
        w_lz_blank = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_lz_run      = w_lz_run && (r_display[NUM_DIGITS-1-k] == 4'd0);
            w_lz_blank[k] = w_lz_run && (k != NUM_DIGITS - 1);
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    logic [3:0]  w_number;
    logic        w_blank;
    logic [10:0] w_glyph_x;

    // Bounds are monotonic, so exactly one slot (or none) matches.
    always_comb begin
        w_number  = 4'd0;
        w_blank   = 1'b1;
        w_glyph_x = x_in;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_ge[k] && !w_ge[k+1]) begin
                w_number  = r_display[NUM_DIGITS-1-k];
                w_blank   = w_lz_blank[k];
                w_glyph_x = w_bound[k][10:0];
            end
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            number_out  <= '0;
            glyph_x_out <= '0;
            glyph_y_out <= '0;
            hcount_out  <= '0;
            vcount_out  <= '0;
            blank_out   <= 1'b0;
        end else begin
            number_out  <= w_number;
            glyph_x_out <= w_glyph_x;
            glyph_y_out <= y_in;
            hcount_out  <= hcount_in;
            vcount_out  <= vcount_in;
            blank_out   <= w_blank;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_score_digit_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_digit_controller
// Description : Directed self-checking bench for score_digit_controller.
//               Honours LEADING_ZERO_BLANK_EN for blank expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_digit_controller;

    localparam int NUM_DIGITS = 4;
    localparam int SCORE_W    = 14;
    localparam int GLYPH_W    = 24;
    localparam int GLYPH_H    = 24;

    logic               pixel_clk_in = 1'b0;
    logic               rst_n_in     = 1'b0;
    logic [SCORE_W-1:0] score_in     = '0;
    logic               score_valid_in = 1'b0;
    logic               frame_start_in = 1'b0;
    logic [10:0]        x_in      = 11'd100;
    logic [9:0]         y_in      = 10'd50;
    logic [10:0]        hcount_in = '0;
    logic [9:0]         vcount_in = '0;
    logic [3:0]         number_out;
    logic [10:0]        glyph_x_out;
    logic [9:0]         glyph_y_out;
    logic [10:0]        hcount_out;
    logic [9:0]         vcount_out;
    logic               blank_out;
    logic               busy_out;

    int errors = 0;
    int checks = 0;

    score_digit_controller #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCORE_W    (SCORE_W),
        .GLYPH_W    (GLYPH_W),
        .GLYPH_H    (GLYPH_H)
    ) dut (
        .pixel_clk_in   (pixel_clk_in),
        .rst_n_in       (rst_n_in),
        .score_in       (score_in),
        .score_valid_in (score_valid_in),
        .frame_start_in (frame_start_in),
        .x_in           (x_in),
        .y_in           (y_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .number_out     (number_out),
        .glyph_x_out    (glyph_x_out),
        .glyph_y_out    (glyph_y_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .blank_out      (blank_out),
        .busy_out       (busy_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk_in);
        #1;
    endtask

    task automatic send_score(input int v);
        score_in       = SCORE_W'(v);
        score_valid_in = 1'b1;
        tick();
        score_valid_in = 1'b0;
    endtask

    task automatic commit();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
    endtask

    // Sweep the left edge of each slot; exp holds the 4 displayed BCD digits.
    task automatic check_display(input string tag, input logic [15:0] exp);
        logic [15:0] e;
        logic [3:0]  d;
        logic        lz;
        logic        eb;
        e  = exp;
        lz = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            d = e[4*(NUM_DIGITS-1-k) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            lz = lz && (d == 4'd0);
            eb = lz && (k != NUM_DIGITS - 1);
`else
            lz = 1'b0;
            eb = lz;
`endif
            hcount_in = 11'(100 + k * GLYPH_W);
            vcount_in = 10'(60 + k);
            tick();
            check($sformatf("%s num slot%0d", tag, k), 32'(number_out), 32'(d));
            check($sformatf("%s blank slot%0d", tag, k), 32'(blank_out), 32'(eb));
            check($sformatf("%s gx slot%0d", tag, k), 32'(glyph_x_out), 32'(100 + k * GLYPH_W));
            check($sformatf("%s hcnt slot%0d", tag, k), 32'(hcount_out), 32'(100 + k * GLYPH_W));
            check($sformatf("%s vcnt slot%0d", tag, k), 32'(vcount_out), 32'(60 + k));
        end
        check($sformatf("%s gy", tag), 32'(glyph_y_out), 32'd50);
    endtask

    initial begin
        // ---- reset state ----
        #12;
        check("rst busy", 32'(busy_out), 32'd0);
        check("rst number", 32'(number_out), 32'd0);
        check("rst blank", 32'(blank_out), 32'd0);
        check("rst hcount", 32'(hcount_out), 32'd0);
        @(negedge pixel_clk_in);
        rst_n_in = 1'b1;
        tick();
        check_display("init", 16'h0000);

        // ---- 1234: latency of busy and full conversion ----
        send_score(1234);
        check("1234 busy E1", 32'(busy_out), 32'd0);
        tick();
        check("1234 busy E2", 32'(busy_out), 32'd1);
        repeat (14) tick();
        check("1234 busy ready", 32'(busy_out), 32'd1);
        check_display("1234 precommit", 16'h0000);
        commit();
        check("1234 busy after commit", 32'(busy_out), 32'd0);
        check_display("1234", 16'h1234);
        // slot boundaries
        hcount_in = 11'd99;  tick();
        check("edge 99 blank", 32'(blank_out), 32'd1);
        check("edge 99 num", 32'(number_out), 32'd0);
        hcount_in = 11'd123; tick();
        check("edge 123 num", 32'(number_out), 32'd1);
        check("edge 123 blank", 32'(blank_out), 32'd0);
        hcount_in = 11'd195; tick();
        check("edge 195 num", 32'(number_out), 32'd4);
        hcount_in = 11'd196; tick();
        check("edge 196 blank", 32'(blank_out), 32'd1);

        // ---- 42 ----
        send_score(42);
        repeat (20) tick();
        commit();
        check_display("42", 16'h0042);

        // ---- 12000 saturates ----
        send_score(12000);
        repeat (20) tick();
        commit();
        check_display("12000", 16'h9999);

        // ---- 500 ready, then 7 arrives before the frame ----
        send_score(500);
        repeat (20) tick();
        send_score(7);
        check_display("500 held", 16'h9999);
        commit();
        check_display("500", 16'h0500);
        repeat (20) tick();
        check("7 ready busy", 32'(busy_out), 32'd1);
        commit();
        check_display("7", 16'h0007);

        // ---- frame_start on the final CONVERT cycle ----
        send_score(3);
        repeat (14) tick();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        check("late frame busy", 32'(busy_out), 32'd1);
        check_display("late frame", 16'h0007);
        commit();
        check_display("3", 16'h0003);

        // ---- async reset mid-conversion ----
        send_score(9);
        repeat (5) tick();
        check("mid busy", 32'(busy_out), 32'd1);
        #2 rst_n_in = 1'b0;
        #1;
        check("async busy", 32'(busy_out), 32'd0);
        check("async hcount", 32'(hcount_out), 32'd0);
        check("async gx", 32'(glyph_x_out), 32'd0);
        check("async gy", 32'(glyph_y_out), 32'd0);
        repeat (2) @(posedge pixel_clk_in);
        @(negedge pixel_clk_in);
        rst_n_in = 1'b1;
        tick();
        check("post rst busy", 32'(busy_out), 32'd0);
        check_display("post rst", 16'h0000);
        repeat (20) tick();
        check("post rst idle", 32'(busy_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
